atcaxi2tluh500_chan_arbiter: RTL

//  - N-way valid/ready arbiter that shares one downstream bridge channel, normally the input of that

---
 rtl/atcaxi2tluh500_chan_arbiter_pkg.sv | 23 ++
 rtl/atcaxi2tluh500_rr_pick.sv | 32 +++
 rtl/atcaxi2tluh500_chan_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/atcaxi2tluh500_chan_arbiter_pkg.sv
// Shared definitions for the bridge channel arbiter: requester limit, state encoding, clog2 helper.
// Optional feature macro used by the arbiter: ATCAXI2TLUH500_ARB_URGENT_EN.
package atcaxi2tluh500_chan_arbiter_pkg;

    localparam int ARB_NREQ_MAX = 8;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/atcaxi2tluh500_rr_pick.sv
// Combinational round-robin picker: first set bit of req, scanning from ptr+1 with wrap.
module atcaxi2tluh500_rr_pick
    import atcaxi2tluh500_chan_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // The requester just served sits at ptr, so it is examined last.
    always_comb begin
        int idx;
        logic [IDW-1:0] idx_w;
        idx    = 0;
        idx_w  = '0;
        gnt_id = '0;
        any    = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx   = (int'(ptr) + i) % NREQ;
            idx_w = IDW'(idx);
            if (!any && req[idx_w]) begin
                any    = 1'b1;
                gnt_id = idx_w;
            end
        end
    end

endmodule

// File: rtl/atcaxi2tluh500_chan_arbiter.sv
// N-way valid/ready round-robin arbiter holding its grant for a whole message, zero-latency path.
// Optional urgent-first arbitration enabled by defining ATCAXI2TLUH500_ARB_URGENT_EN.
module atcaxi2tluh500_chan_arbiter
    import atcaxi2tluh500_chan_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clk_en,
    input  logic [NREQ-1:0]    i_valid,
    input  logic [NREQ-1:0]    i_last,
    input  logic [NREQ-1:0]    i_urgent,
    output logic [NREQ-1:0]    i_ready,
    input  logic [NREQ*DW-1:0] din,
    output logic               o_valid,
    input  logic               o_ready,
    output logic               o_last,
    output logic [IDW-1:0]     o_gnt_id,
    output logic [DW-1:0]      dout
);

    generate
        if (NREQ < 2 || NREQ > ARB_NREQ_MAX) begin : g_bad_nreq
            $error("atcaxi2tluh500_chan_arbiter: NREQ out of range 2..ARB_NREQ_MAX");
        end
        if (IDW != clog2(NREQ)) begin : g_bad_idw
            $error("atcaxi2tluh500_chan_arbiter: IDW must equal clog2(NREQ)");
        end
    endgenerate

    arb_state_e     state, state_nxt;
    logic [IDW-1:0] lock_id, lock_id_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0] rr_id, arb_id, gnt;
    logic           rr_any, arb_any, sel_valid, acc;
    logic [DW-1:0]  din_arr [NREQ];

    atcaxi2tluh500_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .req    (i_valid),
        .ptr    (rr_ptr),
        .gnt_id (rr_id),
        .any    (rr_any)
    );

`ifdef ATCAXI2TLUH500_ARB_URGENT_EN
    logic [NREQ-1:0] urg_req;
    logic [IDW-1:0]  urg_id;
    logic            urg_any;

    assign urg_req = i_valid & i_urgent;

    atcaxi2tluh500_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_urg_pick (
        .req    (urg_req),
        .ptr    (rr_ptr),
        .gnt_id (urg_id),
        .any    (urg_any)
    );

    assign arb_id  = urg_any ? urg_id : rr_id;
    assign arb_any = urg_any | rr_any;
`else
    logic unused_urgent;

    assign unused_urgent = ^i_urgent;
    assign arb_id        = rr_id;
    assign arb_any       = rr_any;
`endif

    for (genvar k = 0; k < NREQ; k++) begin : g_din
        assign din_arr[k] = din[k*DW +: DW];
    end

    // A locked grant ignores all other requesters, including during a source bubble.
    assign gnt       = (state == ST_LOCK) ? lock_id : arb_id;
    assign sel_valid = (state == ST_LOCK) ? i_valid[lock_id] : arb_any;
    assign acc       = sel_valid & o_ready & clk_en;

    assign o_valid  = sel_valid;
    assign o_gnt_id = gnt;
    assign o_last   = sel_valid & i_last[gnt];
    assign dout     = sel_valid ? din_arr[gnt] : '0;
    assign i_ready  = acc ? (NREQ'(1) << gnt) : '0;

    // Lock on any offer that is not a completed last beat, so a stalled offer keeps its grant.
    always_comb begin
        state_nxt   = state;
        lock_id_nxt = lock_id;
        rr_ptr_nxt  = rr_ptr;
        case (state)
            ST_ARB: begin
                if (clk_en && sel_valid && !(acc && o_last)) begin
                    state_nxt   = ST_LOCK;
                    lock_id_nxt = gnt;
                end
            end
            ST_LOCK: begin
                if (acc && o_last) begin
                    state_nxt = ST_ARB;
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
        if (acc && o_last) begin
            rr_ptr_nxt = gnt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_ARB;
            lock_id <= '0;
            rr_ptr  <= IDW'(NREQ - 1);
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

endmodule
